wb_bnn_stream_if: RTL and testbench
===================================

Name: wb_bnn_stream_if

Overview:
Wishbone slave that sits between the wrapper's Wishbone bus and the binary-neural-network core. It buffers 32-bit input words written by the management SoC into a FIFO, streams them to the core over a valid/ready interface, captures the core's result word, and raises an interrupt when a result is pending. The wrapper instantiates it inside the user project, on the same wb_clk_i domain.

Parameters:
BASE_ADDR, 32'h3000_0000, base of the 16-byte register window; wbs_adr_i[31:4] is compared with BASE_ADDR[31:4]
DEPTH, 8, input FIFO depth in 32-bit words; power of two, at least 2
CW, $clog2(DEPTH)+1, width of the occupancy count

Ports:
wb_clk_i  input  1  clock; all logic is on the rising edge
wb_rst_i  input  1  reset, asynchronous, active-high
wbs_cyc_i  input  1  Wishbone cycle
wbs_stb_i  input  1  Wishbone strobe
wbs_we_i  input  1  1 = write
wbs_sel_i  input  4  byte selects
wbs_adr_i  input  32  byte address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
m_data  output  32  FIFO head word to the core
m_valid  output  1  FIFO non-empty
m_ready  input  1  core accepts the head word
res_data  input  32  result from the core
res_valid  input  1  one-cycle result strobe
user_irq  output  3  interrupts; [0] = result pending, [2:1] tied 0

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, FIFO empty (m_valid=0, m_data=0), count=0, ovf=0, irq_en=0, result=0, res_pend=0, user_irq=0.
- Request: req = cyc & stb & ~wbs_ack_o. Each req produces exactly one ack, registered the cycle after req. The ack lasts one cycle. Side effects (push, clear, read-clear) happen on the same edge that sets ack. No back-to-back ack without an intervening low cycle.
- Addresses outside the window are still acked. Reads return 0; writes have no effect.
- Register map (offset = wbs_adr_i[3:2]):
  - 0 DATA, write only; a read returns 0. A write pushes wbs_dat_i; wbs_sel_i is ignored.
  - 1 STATUS, read {26'b0, res_pend, ovf, full, empty, count[1:0]}. When DEPTH>4, count is also readable at CTRL[31:24]. Writing 1 to bit3 with sel[0] clears ovf.
  - 2 RESULT, read only. A read returns the result register and clears res_pend on the ack edge.
  - 3 CTRL, bit0 = irq_en (R/W, sel[0]); bits[31:24] = count (RO, zero-extended).
- FIFO push:
  - A push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs on the same edge.
  - Otherwise the word is dropped, ovf is set (sticky), and the ack still occurs.
- FIFO pop: occurs on any edge with m_valid & m_ready.
- Simultaneous push and pop: count is unchanged, and the head advances correctly. The depth-1 case is handled.
- Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- m_data is the head entry. m_valid=~empty. m_data is held stable while m_valid & ~m_ready.
- Result capture:
  - res_valid loads the result register and sets res_pend.
  - If a new result arrives while one is pending, it overwrites the register; res_pend stays 1.
  - If res_valid and a RESULT read coincide on the same edge, the new value is captured and res_pend stays 1.
- user_irq[0] = res_pend & irq_en, registered one cycle after res_pend changes.
- Asynchronous reset mid-transaction drops any pending ack and empties the FIFO. The bus master must retry.

Test Plan:
- Reset: assert wb_rst_i asynchronously mid-cycle with the FIFO holding 3 words -> all outputs 0 immediately, STATUS reads 0x4 (empty) after release.
- Push/stream: write 0xA5A5_0001..0xA5A5_0003 to BASE+0 with m_ready=0 -> STATUS count=3, m_data=0xA5A5_0001. Raise m_ready -> the three words appear in order on consecutive cycles, then m_valid=0.
- Overflow: with DEPTH=8 and m_ready=0, write 9 words -> 9 acks, STATUS full=1 and ovf=1, word 9 absent from the stream. Write 0x8 to STATUS -> ovf=0.
- Full with concurrent pop: FIFO full, m_ready=1 on the push edge -> push accepted, ovf stays 0, count stays 8.
- Result/IRQ: CTRL=1, pulse res_valid with res_data=0x0000_00C3 -> user_irq[0]=1. Read BASE+8 -> 0xC3, then user_irq[0]=0 and res_pend=0.
- Decode: read BASE+0x10 and 0x0000_0000 -> each acked in one cycle with dat=0. Writes to those addresses leave all state unchanged.

Source files
------------

// File: rtl/wb_bnn_stream_if_if.sv
// wb_bnn_stream_if_if: Wishbone slave bus, core stream, result and irq signals of the BNN stream bridge
interface wb_bnn_stream_if_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] res_data;
    logic        res_valid;
    logic [2:0]  user_irq;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  m_ready, res_data, res_valid,
        output wbs_ack_o, wbs_dat_o, m_data, m_valid, user_irq
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output m_ready, res_data, res_valid,
        input  wbs_ack_o, wbs_dat_o, m_data, m_valid, user_irq
    );
endinterface

// File: rtl/wb_bnn_stream_if.sv
// wb_bnn_stream_if: Wishbone slave buffering input words into a FIFO streamed to the BNN core, with result capture and irq
module wb_bnn_stream_if #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8,
    parameter int          CW        = $clog2(DEPTH) + 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_bnn_stream_if_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic          ack, ovf, irq_en, res_pend, irq;
    logic [31:0]   dat_o, result;
    logic          req, hit, wr, rd, push_req, push_ok, pop, full, empty;
    logic [1:0]    off;
    logic [31:0]   status, ctrl, rd_mux;
    logic          unused;

    assign req      = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack;
    assign hit      = bus.wbs_adr_i[31:4] == BASE_ADDR[31:4];
    assign off      = bus.wbs_adr_i[3:2];
    assign wr       = req & hit & bus.wbs_we_i;
    assign rd       = req & hit & ~bus.wbs_we_i;
    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign pop      = ~empty & bus.m_ready;
    assign push_req = wr & (off == 2'd0);
    // a full FIFO still takes the word when the head leaves on the same edge
    assign push_ok  = push_req & (~full | pop);
    assign status   = {26'b0, res_pend, ovf, full, empty, count[1:0]};
    assign ctrl     = {8'(count), 23'b0, irq_en};
    assign rd_mux   = off == 2'd1 ? status : off == 2'd2 ? result : off == 2'd3 ? ctrl : '0;
    assign unused   = &{1'b0, bus.wbs_adr_i[1:0], bus.wbs_sel_i[3:1]};

    assign bus.wbs_ack_o = ack;
    assign bus.wbs_dat_o = dat_o;
    assign bus.m_valid   = ~empty;
    assign bus.m_data    = empty ? '0 : mem[rp];
    assign bus.user_irq  = {2'b00, irq};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack      <= 1'b0;
            dat_o    <= '0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            irq_en   <= 1'b0;
            result   <= '0;
            res_pend <= 1'b0;
            irq      <= 1'b0;
        end else begin
            ack   <= req;
            dat_o <= rd ? rd_mux : '0;
            if (push_ok) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
            if (push_req & ~push_ok) ovf <= 1'b1;
            else if (wr & (off == 2'd1) & bus.wbs_sel_i[0] & bus.wbs_dat_i[3]) ovf <= 1'b0;
            if (wr & (off == 2'd3) & bus.wbs_sel_i[0]) irq_en <= bus.wbs_dat_i[0];
            // a fresh result wins over a RESULT read on the same edge
            if (bus.res_valid) begin
                result   <= bus.res_data;
                res_pend <= 1'b1;
            end else if (rd & (off == 2'd2)) res_pend <= 1'b0;
            irq <= res_pend & irq_en;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem[wp] <= bus.wbs_dat_i;
    end
endmodule

// File: tb/tb_wb_bnn_stream_if.sv
// tb_wb_bnn_stream_if: directed bench with read-data and stream scoreboards for wb_bnn_stream_if
module tb_wb_bnn_stream_if;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_bnn_stream_if_if bus();

    wb_bnn_stream_if #(.BASE_ADDR(BASE), .DEPTH(8)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd[$];
    logic [31:0] exp_st[$];
    logic is_rd = 1'b0;
    logic pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.wbs_ack_o && is_rd) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_extra got %h want no read", bus.wbs_dat_o);
            end else begin
                e = exp_rd.pop_front();
                check("rd_data", bus.wbs_dat_o, e);
            end
        end
        if (bus.m_valid && bus.m_ready) begin
            if (exp_st.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL st_extra got %h want no word", bus.m_data);
            end else begin
                e = exp_st.pop_front();
                check("st_data", bus.m_data, e);
            end
        end
    end

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, output int n);
        is_rd         = ~we;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (pulse) begin
                bus.m_ready   = 1'b0;
                bus.res_valid = 1'b0;
                pulse         = 1'b0;
            end
        end while (!bus.wbs_ack_o && n < 10);
        if (!bus.wbs_ack_o) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout got no ack want ack adr %h", adr);
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        int n;
        xfer(1'b1, adr, dat, 4'hf, n);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp);
        int n;
        exp_rd.push_back(exp);
        xfer(1'b0, adr, 32'h0, 4'hf, n);
    endtask

    task automatic res_pulse(input logic [31:0] d);
        bus.res_data  = d;
        bus.res_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        bus.m_ready   = 1'b0;
        bus.res_data  = '0;
        bus.res_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("rst_valid", 32'(bus.m_valid), 32'h0);
        check("rst_irq", 32'(bus.user_irq), 32'h0);
        rd(BASE + 32'h4, 32'h0000_0004);

        // push three, then stream them out
        for (int i = 1; i <= 3; i++) begin
            wr(BASE, 32'hA5A5_0000 + 32'(i));
            exp_st.push_back(32'hA5A5_0000 + 32'(i));
        end
        rd(BASE + 32'h4, 32'h0000_0003);
        rd(BASE + 32'hC, 32'h0300_0000);
        check("head_data", bus.m_data, 32'hA5A5_0001);
        check("head_valid", 32'(bus.m_valid), 32'h1);
        bus.m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("drain_valid", 32'(bus.m_valid), 32'h0);
        bus.m_ready = 1'b0;

        // overflow: ninth word dropped
        for (int i = 0; i < 9; i++) begin
            wr(BASE, 32'hB000_0000 + 32'(i));
            if (i < 8) exp_st.push_back(32'hB000_0000 + 32'(i));
        end
        rd(BASE + 32'h4, 32'h0000_0018);
        rd(BASE + 32'hC, 32'h0800_0000);
        wr(BASE + 32'h4, 32'h0000_0008);
        rd(BASE + 32'h4, 32'h0000_0008);

        // full FIFO with a pop on the push edge
        exp_st.push_back(32'hC000_0009);
        bus.m_ready = 1'b1;
        pulse = 1'b1;
        wr(BASE, 32'hC000_0009);
        rd(BASE + 32'h4, 32'h0000_0008);
        bus.m_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        check("drain2_valid", 32'(bus.m_valid), 32'h0);
        check("st_queue", 32'(exp_st.size()), 32'h0);

        // result capture and interrupt
        wr(BASE + 32'hC, 32'h0000_0001);
        rd(BASE + 32'hC, 32'h0000_0001);
        res_pulse(32'h0000_00C3);
        @(posedge clk);
        #1;
        check("irq_set", 32'(bus.user_irq), 32'h1);
        rd(BASE + 32'h4, 32'h0000_0024);
        rd(BASE + 32'h8, 32'h0000_00C3);
        check("irq_clr", 32'(bus.user_irq), 32'h0);
        rd(BASE + 32'h4, 32'h0000_0004);
        res_pulse(32'h0000_0055);
        bus.res_data  = 32'h0000_0077;
        bus.res_valid = 1'b1;
        pulse = 1'b1;
        rd(BASE + 32'h8, 32'h0000_0055);
        rd(BASE + 32'h4, 32'h0000_0024);
        rd(BASE + 32'h8, 32'h0000_0077);
        rd(BASE + 32'h4, 32'h0000_0004);

        // decode: outside the window acks with zero and has no effect
        exp_rd.push_back(32'h0);
        xfer(1'b0, BASE + 32'h10, 32'h0, 4'hf, n);
        check("lat_out1", 32'(n), 32'h1);
        exp_rd.push_back(32'h0);
        xfer(1'b0, 32'h0000_0000, 32'h0, 4'hf, n);
        check("lat_out0", 32'(n), 32'h1);
        rd(BASE, 32'h0);
        wr(BASE + 32'h10, 32'hFFFF_FFFF);
        wr(32'h0000_0000, 32'h0000_0001);
        wr(BASE + 32'h1C, 32'h0000_0000);
        check("dec_valid", 32'(bus.m_valid), 32'h0);
        rd(BASE + 32'h4, 32'h0000_0004);
        rd(BASE + 32'hC, 32'h0000_0001);

        // asynchronous reset with data buffered and a result pending
        for (int i = 0; i < 3; i++) wr(BASE, 32'hD000_0000 + 32'(i));
        res_pulse(32'h0000_0099);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(bus.m_valid), 32'h1);
        check("pre_rst_irq", 32'(bus.user_irq), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.m_valid), 32'h0);
        check("arst_data", bus.m_data, 32'h0);
        check("arst_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("arst_dat", bus.wbs_dat_o, 32'h0);
        check("arst_irq", 32'(bus.user_irq), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        rd(BASE + 32'h4, 32'h0000_0004);
        rd(BASE + 32'hC, 32'h0000_0000);
        rd(BASE + 32'h8, 32'h0000_0000);

        repeat (2) @(posedge clk);
        check("rd_queue", 32'(exp_rd.size()), 32'h0);
        check("st_queue_end", 32'(exp_st.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
